ahb_master_arbiter: RTL and testbench



---
 rtl/ahb_arb_if.sv | 24 ++
 rtl/ahb_master_arbiter.sv | 143 ++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ahb_arb_if.sv
// Bus-ownership signals between the AHB master arbiter and the bus/CPU side.
// The "master" modport is the arbiter's view; "slave" is the view of the surrounding bus logic.
interface ahb_arb_if #(
    parameter int NM = 2
);
    logic [NM-1:0] req;
    logic          HREADY;
    logic [1:0]    HTRANS;
    logic          bus_master_ack;
    logic          bus_master_req;
    logic [NM-1:0] gnt;
    logic [2:0]    hmaster;
    logic          cpu_own;

    modport master (
        input  req, HREADY, HTRANS, bus_master_ack,
        output bus_master_req, gnt, hmaster, cpu_own
    );

    modport slave (
        output req, HREADY, HTRANS, bus_master_ack,
        input  bus_master_req, gnt, hmaster, cpu_own
    );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Shares the system AHB between the CPU (default owner) and NM secondary masters:
// round-robin grants with a bounded hold time and a one-cycle parked handover between owners.
module ahb_master_arbiter #(
    parameter int NM       = 2,
    parameter int HOLD_MAX = 16,
    parameter int CW       = 8
) (
    input  logic       HCLK,
    input  logic       rst,
    ahb_arb_if.master  bus
);
    localparam logic [1:0] ST_CPU      = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_GRANT    = 2'd2;
    localparam logic [1:0] ST_PARK     = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [2:0]    ptr_reg, ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [NM-1:0] gnt_reg, gnt_next;
    logic [2:0]    hmaster_reg, hmaster_next;
    logic          cpu_own_reg, cpu_own_next;
    logic          bmr_reg, bmr_next;

    logic [NM-1:0] req_hi;
    logic [NM-1:0] req_other;
    logic [2:0]    win_idx;
    logic [2:0]    win_ptr;
    logic          any_req;
    logic          xfer;
    logic [CW-1:0] cnt_inc;
    logic          leave;
    logic          unused_htrans;

    assign unused_htrans = bus.HTRANS[0];

    // req_hi: requesters at or above the RR pointer; req_other: everyone but the owner.
    for (genvar gi = 0; gi < NM; gi++) begin : g_req
        assign req_hi[gi]    = bus.req[gi] && (3'(gi) >= ptr_reg);
        assign req_other[gi] = bus.req[gi] && (3'(gi) != hmaster_reg);
    end

    assign any_req = |bus.req;

    // Lowest set bit at/above ptr wins; if none, wrap to the lowest set bit overall.
    always_comb begin
        win_idx = '0;
        if (|req_hi) begin
            for (int i = NM - 1; i >= 0; i--) begin
                if (req_hi[i]) win_idx = 3'(i);
            end
        end else begin
            for (int i = NM - 1; i >= 0; i--) begin
                if (bus.req[i]) win_idx = 3'(i);
            end
        end
    end

    assign win_ptr = (win_idx == 3'(NM - 1)) ? 3'd0 : win_idx + 3'd1;

    assign xfer    = bus.HREADY && bus.HTRANS[1];
    assign cnt_inc = (xfer && (cnt_reg != '1)) ? cnt_reg + 1'b1 : cnt_reg;

    // The current cycle's accepted transfer counts toward the hold limit.
    assign leave = !bus.req[hmaster_reg[$clog2(NM > 1 ? NM : 2)-1:0]]
                || ((HOLD_MAX != 0) && (cnt_inc >= CW'(HOLD_MAX)) && (|req_other));

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        cnt_next     = cnt_reg;
        gnt_next     = gnt_reg;
        hmaster_next = hmaster_reg;
        cpu_own_next = cpu_own_reg;
        bmr_next     = bmr_reg;
        case (state_reg)
            ST_CPU: begin
                if (any_req) begin
                    state_next = ST_WAIT_ACK;
                    bmr_next   = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                if (!any_req) begin
                    state_next = ST_CPU;
                    bmr_next   = 1'b0;
                end else if (bus.bus_master_ack && bus.HREADY) begin
                    state_next   = ST_GRANT;
                    gnt_next     = NM'(1) << win_idx;
                    hmaster_next = win_idx;
                    ptr_next     = win_ptr;
                    cpu_own_next = 1'b0;
                    cnt_next     = '0;
                end
            end
            ST_GRANT: begin
                cnt_next = cnt_inc;
                if (bus.HREADY && leave) begin
                    state_next = ST_PARK;
                    gnt_next   = '0;
                end
            end
            default: begin
                if (any_req) begin
                    state_next   = ST_GRANT;
                    gnt_next     = NM'(1) << win_idx;
                    hmaster_next = win_idx;
                    ptr_next     = win_ptr;
                    cnt_next     = '0;
                end else begin
                    state_next   = ST_CPU;
                    bmr_next     = 1'b0;
                    cpu_own_next = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (rst) begin
            state_reg   <= ST_CPU;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
            gnt_reg     <= '0;
            hmaster_reg <= '0;
            cpu_own_reg <= 1'b1;
            bmr_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
            gnt_reg     <= gnt_next;
            hmaster_reg <= hmaster_next;
            cpu_own_reg <= cpu_own_next;
            bmr_reg     <= bmr_next;
        end
    end

    assign bus.gnt            = gnt_reg;
    assign bus.hmaster        = hmaster_reg;
    assign bus.cpu_own        = cpu_own_reg;
    assign bus.bus_master_req = bmr_reg;
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter (NM=2, HOLD_MAX=4): a cycle-by-cycle vector table
// for handshake/release cases plus hand-written sequences for round-robin, hold and reset.
module tb_ahb_master_arbiter;
    localparam int NM = 2;

    logic HCLK = 1'b0;
    logic rst  = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    always #5 HCLK = ~HCLK;

    ahb_arb_if #(.NM(NM)) bus ();

    ahb_master_arbiter #(.NM(NM), .HOLD_MAX(4), .CW(8)) dut (
        .HCLK (HCLK),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0] req;
        logic       ack;
        logic       hready;
        logic [1:0] exp_gnt;
        logic       exp_bmr;
        logic       exp_own;
        logic [2:0] exp_hm;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] g, input logic b, input logic o);
        check({tag, " gnt"}, 32'(bus.gnt), 32'(g));
        check({tag, " bus_master_req"}, 32'(bus.bus_master_req), 32'(b));
        check({tag, " cpu_own"}, 32'(bus.cpu_own), 32'(o));
    endtask

    function automatic vec_t mk(input logic [1:0] r, input logic a, input logic h,
                                input logic [1:0] g, input logic b, input logic o,
                                input logic [2:0] hm);
        vec_t v;
        v.req = r; v.ack = a; v.hready = h;
        v.exp_gnt = g; v.exp_bmr = b; v.exp_own = o; v.exp_hm = hm;
        return v;
    endfunction

    logic [1:0] rr_exp [15];

    initial begin
        // req, ack, hready -> gnt, bus_master_req, cpu_own, hmaster
        vecs[0]  = mk(2'b01, 0, 1, 2'b00, 1, 1, 0);
        vecs[1]  = mk(2'b01, 0, 1, 2'b00, 1, 1, 0);
        vecs[2]  = mk(2'b01, 0, 1, 2'b00, 1, 1, 0);
        vecs[3]  = mk(2'b01, 1, 1, 2'b01, 1, 0, 0);
        vecs[4]  = mk(2'b01, 1, 1, 2'b01, 1, 0, 0);
        vecs[5]  = mk(2'b00, 1, 1, 2'b00, 1, 0, 0);
        vecs[6]  = mk(2'b00, 1, 1, 2'b00, 0, 1, 0);
        vecs[7]  = mk(2'b01, 0, 1, 2'b00, 1, 1, 0);
        vecs[8]  = mk(2'b00, 0, 1, 2'b00, 0, 1, 0);
        vecs[9]  = mk(2'b01, 0, 1, 2'b00, 1, 1, 0);
        vecs[10] = mk(2'b00, 1, 1, 2'b00, 0, 1, 0);
        vecs[11] = mk(2'b01, 1, 0, 2'b00, 1, 1, 0);
        vecs[12] = mk(2'b01, 1, 0, 2'b00, 1, 1, 0);
        vecs[13] = mk(2'b01, 1, 1, 2'b01, 1, 0, 0);
        vecs[14] = mk(2'b00, 1, 0, 2'b01, 1, 0, 0);
        vecs[15] = mk(2'b00, 1, 1, 2'b00, 1, 0, 0);
        vecs[16] = mk(2'b10, 1, 1, 2'b10, 1, 0, 1);
        vecs[17] = mk(2'b00, 1, 1, 2'b00, 1, 0, 0);
        vecs[18] = mk(2'b00, 1, 1, 2'b00, 0, 1, 0);

        rr_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                   2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                   2'b01, 2'b01, 2'b01, 2'b01, 2'b00};

        bus.req = '0; bus.bus_master_ack = 1'b1; bus.HREADY = 1'b1; bus.HTRANS = 2'b00;
        rst = 1'b1;
        step(); step();
        check_outs("reset", 2'b00, 1'b0, 1'b1);
        check("reset hmaster", 32'(bus.hmaster), 32'd0);
        rst = 1'b0;

        // Idle: no requests, ack high.
        for (int i = 0; i < 20; i++) begin
            step();
            check_outs($sformatf("idle[%0d]", i), 2'b00, 1'b0, 1'b1);
        end
        $display("[TB] idle 20 cycles done");

        // Handshake / release / aborted-request vectors (no counted transfers).
        bus.bus_master_ack = 1'b0;
        for (int i = 0; i < 19; i++) begin
            bus.req = vecs[i].req; bus.bus_master_ack = vecs[i].ack; bus.HREADY = vecs[i].hready;
            step();
            check_outs($sformatf("vec[%0d]", i), vecs[i].exp_gnt, vecs[i].exp_bmr, vecs[i].exp_own);
            if (vecs[i].exp_gnt != 2'b00)
                check($sformatf("vec[%0d] hmaster", i), 32'(bus.hmaster), 32'(vecs[i].exp_hm));
            $display("[TB] vec %0d req=%b ack=%b hready=%b -> gnt=%b bmr=%b own=%b",
                     i, vecs[i].req, vecs[i].ack, vecs[i].hready,
                     bus.gnt, bus.bus_master_req, bus.cpu_own);
        end

        // Both requesting, one transfer per cycle: tenures of 4 transfers separated by PARK.
        bus.req = 2'b11; bus.bus_master_ack = 1'b1; bus.HREADY = 1'b1; bus.HTRANS = 2'b10;
        step();
        check_outs("rr wait", 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            step();
            check_outs($sformatf("rr[%0d]", i), rr_exp[i], 1'b1, 1'b0);
        end
        $display("[TB] round-robin hold sequence done");
        bus.req = 2'b00;
        step();
        check_outs("rr to cpu", 2'b00, 1'b0, 1'b1);

        // Lone requester is never preempted.
        bus.req = 2'b01;
        step(); step();
        check_outs("lone grant", 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step();
            check($sformatf("lone[%0d] gnt", i), 32'(bus.gnt), 32'(2'b01));
        end
        $display("[TB] lone requester 50 transfers done");

        // Second requester appears while HREADY is low: handover waits for HREADY.
        bus.req = 2'b11; bus.HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hready_low[%0d] gnt", i), 32'(bus.gnt), 32'(2'b01));
        end
        bus.HREADY = 1'b1;
        step();
        check_outs("hready park", 2'b00, 1'b1, 1'b0);
        step();
        check_outs("hready next", 2'b10, 1'b1, 1'b0);
        check("hready next hmaster", 32'(bus.hmaster), 32'd1);

        // Reset in the middle of master 1's tenure.
        rst = 1'b1;
        step();
        check_outs("midrst", 2'b00, 1'b0, 1'b1);
        check("midrst hmaster", 32'(bus.hmaster), 32'd0);
        rst = 1'b0;
        step();
        check_outs("postrst wait", 2'b00, 1'b1, 1'b1);
        step();
        check_outs("postrst grant", 2'b01, 1'b1, 1'b0);
        check("postrst hmaster", 32'(bus.hmaster), 32'd0);
        $display("[TB] reset mid-grant done");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
